// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM/owner encodings,
// bus payload widths and the default fetch-starvation limit.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN                 = 32;
  localparam int unsigned BE_W                 = 4;
  localparam int unsigned STARVE_W             = 3;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LS    = 1'b1
  } owner_e;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } bus_payload_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// Load/store wins by default; fetch wins once it has been starved for
// STARVE_LIMIT load/store grants, or when it is the only requester.
// A killed fetch request is never picked.
import mem_port_arbiter_pkg::*;

module mem_arb_pick #(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                if_req,
  input  logic                ls_req,
  input  logic                if_kill,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                pick_if,
  output logic                pick_ls
);

  logic if_ok;
  logic starved;

  // Priority decision with starvation override.
  always_comb begin
    if_ok   = if_req & ~if_kill;
    starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    pick_if = if_ok & (starved | ~ls_req);
    pick_ls = ls_req & ~pick_if;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory bus between instruction fetch and
// load/store. One transaction at a time: IDLE grants and latches the
// payload, ADDR holds bus_req until bus_gnt, WAIT routes bus_rvalid back
// to the owner. Fetch responses orphaned by if_kill are dropped.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  // instruction fetch
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  // load/store
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [BE_W-1:0] ls_be,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  // memory bus
  output logic            bus_req,
  output logic            bus_we,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  arb_state_e          state_q,     state_d;
  owner_e              owner_q,     owner_d;
  logic                drop_q,      drop_d;
  logic [STARVE_W-1:0] starve_q,    starve_d;
  bus_payload_t        pay_q,       pay_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [XLEN-1:0]     if_rdata_q,  if_rdata_d;
  logic [XLEN-1:0]     ls_rdata_q,  ls_rdata_d;

  logic pick_if;
  logic pick_ls;
  logic grant_if;
  logic grant_ls;
  logic fetch_kill;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .if_kill    (if_kill),
    .starve_cnt (starve_q),
    .pick_if    (pick_if),
    .pick_ls    (pick_ls)
  );

  // Grants are only issued from IDLE.
  always_comb begin
    grant_if   = (state_q == IDLE) & pick_if;
    grant_ls   = (state_q == IDLE) & pick_ls;
    fetch_kill = (owner_q == OWN_FETCH) & if_kill;
  end

  // Next-state, payload latch, starvation counter and response routing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    pay_d       = pay_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_if) begin
          owner_d       = OWN_FETCH;
          pay_d.we      = 1'b0;
          pay_d.be      = '1;
          pay_d.addr    = if_addr;
          pay_d.wdata   = '0;
          starve_d      = '0;
          state_d       = ADDR;
        end else if (grant_ls) begin
          owner_d       = OWN_LS;
          pay_d.we      = ls_we;
          pay_d.be      = ls_be;
          pay_d.addr    = ls_addr;
          pay_d.wdata   = ls_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          state_d       = ADDR;
        end
      end

      ADDR: begin
        if (fetch_kill) begin
          drop_d = 1'b1;
        end
        if (bus_gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (fetch_kill) begin
          drop_d = 1'b1;
        end
        if (bus_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_FETCH) begin
            // kill coincident with the response still suppresses it
            if (!drop_q && !if_kill) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = bus_rdata;
            end
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = pay_q.we ? '0 : bus_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_LS;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      pay_q       <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      pay_q       <= pay_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Output drive; combinational grants are forced low while in reset.
  always_comb begin
    if_gnt    = grant_if & reset;
    ls_gnt    = grant_ls & reset;
    bus_req   = (state_q == ADDR);
    bus_we    = pay_q.we;
    bus_be    = pay_q.be;
    bus_addr  = pay_q.addr;
    bus_wdata = pay_q.wdata;
    if_rvalid = if_rvalid_q;
    if_rdata  = if_rdata_q;
    ls_rvalid = ls_rvalid_q;
    ls_rdata  = ls_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters and a memory model
// drive the DUT; a monitor predicts grants and responses from the
// arbitration rules and compares them against the DUT outputs.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory contents as seen by reads.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1234_5678;
  endfunction

  typedef struct {
    bit          fetch;
    bit          drop;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } pay_t;

  // ---------------- scoreboard / monitor state ----------------
  resp_t       exp_q[$];
  pay_t        pay_exp;
  bit          pay_due, outstanding, cur_fetch, due;
  int unsigned streak;
  byte         glog[$];
  bit          m_eif, m_els, m_elig;
  resp_t       m_r;

  // ---------------- stimulus / memory-model state ----------------
  bit          real_rv;
  bit          g_if, g_ls;
  int unsigned rph, dly, rvd, late_rv;
  int unsigned gmin, gmax, rmin, rmax;
  logic [31:0] r_addr;
  logic        r_we;
  bit          auto_if, auto_ls, kill_en, spur_en;
  int unsigned prob;

  // Monitor: predicts each cycle's grant and checks responses in order.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        chk("reset_ctl", {bus_req, bus_we, bus_be, if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 64'd0);
        chk("reset_bus_data", {bus_addr, bus_wdata}, 64'd0);
        chk("reset_rdata", {if_rdata, ls_rdata}, 64'd0);
        exp_q.delete();
        outstanding = 0; due = 0; pay_due = 0; streak = 0;
        continue;
      end
      // response pulse due one cycle after the memory answered
      if (due) begin
        due = 0;
        outstanding = 0;
        if (exp_q.size() == 0) begin
          chk("resp_queue_nonempty", 64'd0, 64'd1);
        end else begin
          m_r = exp_q.pop_front();
          if (m_r.drop) begin
            chk("dropped_fetch_silent", {if_rvalid, ls_rvalid}, 64'd0);
          end else if (m_r.fetch) begin
            chk("if_resp_valid", {if_rvalid, ls_rvalid}, 64'b10);
            chk("if_rdata", if_rdata, m_r.data);
          end else begin
            chk("ls_resp_valid", {if_rvalid, ls_rvalid}, 64'b01);
            chk("ls_rdata", ls_rdata, m_r.data);
          end
        end
      end else begin
        chk("no_unexpected_rvalid", {if_rvalid, ls_rvalid}, 64'd0);
      end
      // a kill anywhere between grant and memory response orphans a fetch
      if (outstanding && cur_fetch && if_kill && exp_q.size() > 0) exp_q[0].drop = 1;
      if (pay_due) begin
        pay_due = 0;
        chk("bus_req_after_gnt", bus_req, 64'd1);
        chk("bus_we_be", {bus_we, bus_be}, {pay_exp.we, pay_exp.be});
        chk("bus_addr", bus_addr, pay_exp.addr);
        chk("bus_wdata", bus_wdata, pay_exp.wdata);
      end
      // arbitration rules
      m_elig = if_req && !if_kill;
      m_eif = 0;
      m_els = 0;
      if (!outstanding) begin
        if (m_elig && (!ls_req || streak == LIMIT)) m_eif = 1;
        else if (ls_req) m_els = 1;
      end
      chk("grant", {if_gnt, ls_gnt}, {m_eif, m_els});
      if (m_eif) begin
        exp_q.push_back('{fetch: 1, drop: 0, data: mem_rd(if_addr)});
        pay_exp = '{we: 1'b0, be: 4'hF, addr: if_addr, wdata: 32'd0};
        streak = 0;
        outstanding = 1; cur_fetch = 1; pay_due = 1;
        glog.push_back(8'd73);
      end else if (m_els) begin
        exp_q.push_back('{fetch: 0, drop: 0, data: ls_we ? 32'd0 : mem_rd(ls_addr)});
        pay_exp = '{we: ls_we, be: ls_be, addr: ls_addr, wdata: ls_wdata};
        streak = if_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
        outstanding = 1; cur_fetch = 0; pay_due = 1;
        glog.push_back(8'd76);
      end
      if (real_rv) due = 1;
    end
  end

  // One clock of stimulus: sample grants, then drive memory and requesters.
  task automatic step();
    @(negedge clk);
    g_if = if_gnt;
    g_ls = ls_gnt;
    @(posedge clk);
    #1;
    bus_gnt = 0; bus_rvalid = 0; real_rv = 0; bus_rdata = $urandom;
    if (!reset) begin
      rph = 0;
    end else begin
      if (rph == 0 && bus_req) begin
        rph = 1;
        dly = $urandom_range(gmax, gmin);
      end
      if (rph == 1) begin
        chk("bus_req_held", bus_req, 64'd1);
        if (dly == 0) begin
          bus_gnt = 1; r_addr = bus_addr; r_we = bus_we;
          rph = 2; rvd = $urandom_range(rmax, rmin);
        end else begin
          dly--;
        end
      end else if (rph == 2) begin
        if (rvd == 0) begin
          bus_rvalid = 1; real_rv = 1; rph = 0;
          bus_rdata = r_we ? $urandom : mem_rd(r_addr);
        end else begin
          rvd--;
        end
      end else if (late_rv > 0) begin
        late_rv--;
        if (late_rv == 0) bus_rvalid = 1;
      end else if (spur_en && $urandom_range(5, 0) == 0) begin
        if ($urandom_range(1, 0) == 1) bus_rvalid = 1;
        else bus_gnt = 1;
      end
    end
    if (g_if) if_req = 0;
    if (g_ls) ls_req = 0;
    if (auto_if && !if_req && $urandom_range(99, 0) < prob) begin
      if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (auto_ls && !ls_req && $urandom_range(99, 0) < prob) begin
      ls_req = 1; ls_we = 1'($urandom_range(1, 0)); ls_be = 4'($urandom_range(15, 1));
      ls_addr = $urandom; ls_wdata = $urandom;
    end
    if (kill_en) if_kill = ($urandom_range(7, 0) == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_gnt(input bit want_if);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(want_if ? g_if : g_ls) && n < 40);
    chk(want_if ? "if_gnt_seen" : "ls_gnt_seen", want_if ? g_if : g_ls, 64'd1);
  endtask

  task automatic set_lat(input int unsigned g0, g1, r0, r1);
    gmin = g0; gmax = g1; rmin = r0; rmax = r1;
  endtask

  string seq;
  int    k;

  initial begin
    reset = 0;
    if_req = 0; if_addr = 0; if_kill = 0;
    ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    rph = 0; late_rv = 0; auto_if = 0; auto_ls = 0; kill_en = 0; spur_en = 0; prob = 0;
    set_lat(0, 0, 0, 0);
    steps(3);
    reset = 1;
    steps(2);

    // single fetch, best-case memory
    if_req = 1; if_addr = 32'h100;
    wait_gnt(1);
    steps(5);

    // contention: both requesters continuously pending
    glog.delete();
    auto_if = 1; auto_ls = 1; prob = 100;
    k = 0;
    while (glog.size() < 6 && k < 60) begin
      step();
      k++;
    end
    auto_if = 0; auto_ls = 0;
    seq = "LLILLI";
    chk("contention_grants", glog.size() >= 6, 64'd1);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("contention_order", glog[i], seq[i]);
    steps(15);

    // kill while fetch waits for bus_gnt
    set_lat(3, 3, 0, 0);
    if_req = 1; if_addr = 32'h200;
    wait_gnt(1);
    if_kill = 1;
    step();
    if_kill = 0;
    steps(8);
    set_lat(0, 0, 0, 0);
    if_req = 1; if_addr = 32'h300;
    wait_gnt(1);
    steps(5);

    // store with delayed bus_gnt
    set_lat(2, 2, 0, 0);
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF;
    wait_gnt(0);
    steps(8);
    set_lat(0, 0, 0, 0);

    // kill at request time blocks the grant for that cycle only
    if_req = 1; if_kill = 1; if_addr = 32'h600;
    step();
    chk("kill_blocks_gnt", g_if, 64'd0);
    if_kill = 0;
    step();
    chk("gnt_after_kill", g_if, 64'd1);
    steps(6);

    // randomized traffic
    set_lat(0, 3, 0, 3);
    auto_if = 1; auto_ls = 1; prob = 40; kill_en = 1; spur_en = 1;
    steps(1500);
    auto_if = 0; auto_ls = 0; kill_en = 0; spur_en = 0; if_kill = 0;
    steps(60);

    // reset during WAIT, then a late memory response
    set_lat(0, 0, 6, 6);
    if_req = 1; if_addr = 32'h500;
    wait_gnt(1);
    step();
    if_req = 1; if_addr = 32'h504;
    reset = 0;
    step();
    if_req = 0;
    reset = 1;
    late_rv = 3;
    steps(10);

    k = 0;
    while ((exp_q.size() != 0 || outstanding) && k < 50) begin
      step();
      k++;
    end
    chk("scoreboard_drained", exp_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
